lcd1602_bus_arbiter: RTL and testbench

- Shares the single HD44780 (16x2) 8-bit write bus between NUM_REQ requesters, e.g. the text/value painter and the custom-character painter.
- Each requester posts one byte (rs + data). The arbiter grants round-robin and generates the enable pulse with fixed setup, pulse, hold and execution-wait timing, derived from the system clock.
- A lock input lets one requester own the bus for a multi-byte burst.
- Replaces the shared-rs/data output muxing and the slow-clock-derived enable.

---
 rtl/lcd1602_bus_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_lcd1602_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_bus_arbiter.sv
// Round-robin arbiter sharing one HD44780 8-bit write bus, with self-timed E pulse and lock bursts.
// Optional LCD_ARB_LONG_CMD_EN: clear/home commands (rs=0, data 0x01..0x03) use LongWaitCyc.
module lcd1602_bus_arbiter #(
    parameter int unsigned NumReq      = 3,
    parameter int unsigned SetupCyc    = 4,
    parameter int unsigned PulseCyc    = 25,
    parameter int unsigned HoldCyc     = 4,
    parameter int unsigned WaitCyc     = 2500,
    parameter int unsigned LongWaitCyc = 100000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NumReq-1:0]     req_i,
    input  logic [NumReq-1:0]     lock_i,
    input  logic [NumReq-1:0]     rs_in_i,
    input  logic [8*NumReq-1:0]   data_in_i,
    output logic [NumReq-1:0]     grant_o,
    output logic [NumReq-1:0]     done_o,
    output logic                  busy_o,
    output logic                  lcd_rs_o,
    output logic                  lcd_rw_o,
    output logic                  lcd_enable_o,
    output logic [7:0]            lcd_data_o
);

    localparam int unsigned MaxA   = (SetupCyc > PulseCyc) ? SetupCyc : PulseCyc;
    localparam int unsigned MaxB   = (HoldCyc > WaitCyc) ? HoldCyc : WaitCyc;
    localparam int unsigned MaxC   = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned MaxCyc = (MaxC > LongWaitCyc) ? MaxC : LongWaitCyc;
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;
    localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StWait} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NumReq-1:0]   grant_q, grant_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic                lcd_rs_q, lcd_rs_d;
    logic [7:0]          lcd_data_q, lcd_data_d;
    logic [IdxW-1:0]     rr_q, rr_d;
    logic                lock_vld_q, lock_vld_d;
    logic [IdxW-1:0]     lock_idx_q, lock_idx_d;

    logic                win_vld;
    logic [IdxW-1:0]     win_idx;
    logic [IdxW-1:0]     cand;
    logic                win_rs;
    logic [7:0]          win_data;
    logic [NumReq-1:0]   win_grant;
    logic [CntW-1:0]     wait_load;
    logic                last;

    assign last = (cnt_q == '0);

    // A held lock wins outright; a dropped lock falls through to round-robin in the same cycle.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        if (lock_vld_q && req_i[lock_idx_q]) begin
            win_vld = 1'b1;
            win_idx = lock_idx_q;
        end else begin
            for (int unsigned k = 0; k < NumReq; k++) begin
                cand = IdxW'((32'(rr_q) + k) % NumReq);
                if (!win_vld && req_i[cand]) begin
                    win_vld = 1'b1;
                    win_idx = cand;
                end
            end
        end
        win_rs    = 1'b0;
        win_data  = 8'h00;
        win_grant = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (win_idx == IdxW'(i)) begin
                win_rs       = rs_in_i[i];
                win_data     = data_in_i[8*i +: 8];
                win_grant[i] = 1'b1;
            end
        end
    end

    always_comb begin
`ifdef LCD_ARB_LONG_CMD_EN
        if (!lcd_rs_q && (lcd_data_q inside {8'h01, 8'h02, 8'h03})) begin
            wait_load = CntW'(LongWaitCyc - 1);
        end else begin
            wait_load = CntW'(WaitCyc - 1);
        end
`else
        wait_load = CntW'(WaitCyc - 1);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            grant_q    <= '0;
            owner_q    <= '0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= 8'h00;
            rr_q       <= '0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_data_q <= lcd_data_d;
            rr_q       <= rr_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_data_d = lcd_data_q;
        rr_d       = rr_q;
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        unique case (state_q)
            StIdle: begin
                if (lock_vld_q && !req_i[lock_idx_q]) begin
                    lock_vld_d = 1'b0;
                end
                if (win_vld) begin
                    state_d    = StSetup;
                    cnt_d      = CntW'(SetupCyc - 1);
                    owner_d    = win_idx;
                    grant_d    = win_grant;
                    lcd_rs_d   = win_rs;
                    lcd_data_d = win_data;
                end
            end
            StSetup: begin
                if (last) begin
                    state_d = StPulse;
                    cnt_d   = CntW'(PulseCyc - 1);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StPulse: begin
                if (last) begin
                    state_d = StHold;
                    cnt_d   = CntW'(HoldCyc - 1);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                if (last) begin
                    state_d = StWait;
                    cnt_d   = wait_load;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StWait: begin
                if (last) begin
                    state_d = StIdle;
                    grant_d = '0;
                    if (lock_i[owner_q]) begin
                        lock_vld_d = 1'b1;
                        lock_idx_d = owner_q;
                    end else begin
                        lock_vld_d = 1'b0;
                        rr_d = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        lcd_enable_o = (state_q == StPulse);
        busy_o       = (state_q != StIdle);
        done_o       = (state_q == StWait && last) ? grant_q : '0;
    end

    assign grant_o    = grant_q;
    assign lcd_rs_o   = lcd_rs_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_data_o = lcd_data_q;

endmodule

// File: tb/tb_lcd1602_bus_arbiter.sv
// Scoreboard bench for lcd1602_bus_arbiter; expected transactions are queued at stimulus time.
module tb_lcd1602_bus_arbiter;

    localparam int NR    = 3;
    localparam int SETUP = 2;
    localparam int PULSE = 3;
    localparam int HOLD  = 1;
    localparam int WAITC = 5;
    localparam int LONGC = 20;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic [NR-1:0]     req_i, lock_i, rs_in_i;
    logic [8*NR-1:0]   data_in_i;
    logic [NR-1:0]     grant_o, done_o;
    logic              busy_o, lcd_rs_o, lcd_rw_o, lcd_enable_o;
    logic [7:0]        lcd_data_o;

    lcd1602_bus_arbiter #(
        .NumReq(NR), .SetupCyc(SETUP), .PulseCyc(PULSE), .HoldCyc(HOLD),
        .WaitCyc(WAITC), .LongWaitCyc(LONGC)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .lock_i(lock_i),
        .rs_in_i(rs_in_i), .data_in_i(data_in_i), .grant_o(grant_o), .done_o(done_o),
        .busy_o(busy_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o),
        .lcd_enable_o(lcd_enable_o), .lcd_data_o(lcd_data_o)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        logic [NR-1:0] grant;
        logic          rs;
        logic [7:0]    data;
        int            wait_c;
        bit            b2b;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_wait(input logic rs, input logic [7:0] d);
`ifdef LCD_ARB_LONG_CMD_EN
        return (!rs && d >= 8'h01 && d <= 8'h03) ? LONGC : WAITC;
`else
        return WAITC;
`endif
    endfunction

    function automatic exp_t mk(input int idx, input logic rs, input logic [7:0] d, input bit b2b);
        exp_t e;
        e.grant  = NR'(1) << idx;
        e.rs     = rs;
        e.data   = d;
        e.wait_c = exp_wait(rs, d);
        e.b2b    = b2b;
        return e;
    endfunction

    // Monitor: pops one entry per grant and checks timing relative to the grant cycle.
    int   mon_cyc = 0;
    int   start_cyc, en_start, prev_start, prev_wait;
    bit   active = 0, have_prev = 0;
    logic prev_grant_any = 0, prev_en = 0;
    exp_t cur;

    always @(posedge clk_i) mon_cyc <= mon_cyc + 1;

    always @(negedge clk_i) begin
        if (reset_i) begin
            active         = 0;
            have_prev      = 0;
            prev_grant_any = 0;
            prev_en        = 0;
        end else begin
            if (grant_o != '0 && !prev_grant_any) begin
                check_eq("sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    cur = sb.pop_front();
                    check_eq("sb_grant", 32'(grant_o), 32'(cur.grant));
                    check_eq("sb_rs", 32'(lcd_rs_o), 32'(cur.rs));
                    check_eq("sb_data", 32'(lcd_data_o), 32'(cur.data));
                    if (cur.b2b && have_prev)
                        check_eq("period", mon_cyc - prev_start, 1 + SETUP + PULSE + HOLD + prev_wait);
                    start_cyc  = mon_cyc;
                    prev_start = mon_cyc;
                    prev_wait  = cur.wait_c;
                    have_prev  = 1;
                    active     = 1;
                end
            end
            if (lcd_enable_o && !prev_en) begin
                check_eq("en_rise", mon_cyc - start_cyc, SETUP);
                en_start = mon_cyc;
            end
            if (!lcd_enable_o && prev_en)
                check_eq("en_width", mon_cyc - en_start, PULSE);
            if (done_o != '0) begin
                check_eq("done_active", 32'(active), 1);
                check_eq("done_grant", 32'(done_o), 32'(cur.grant));
                check_eq("done_time", mon_cyc - start_cyc, SETUP + PULSE + HOLD + cur.wait_c - 1);
                check_eq("done_data", 32'(lcd_data_o), 32'(cur.data));
                check_eq("done_rs", 32'(lcd_rs_o), 32'(cur.rs));
                active = 0;
            end
            prev_grant_any = (grant_o != '0);
            prev_en        = lcd_enable_o;
        end
    end

    task automatic do_reset();
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        req_i   = '0;
        lock_i  = '0;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
    endtask

    task automatic wait_dones(input int n, input int budget);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk_i);
            cyc++;
            if (done_o != '0) seen++;
        end
        check_eq("done_count", seen, n);
        @(posedge clk_i); #1;
    endtask

    // One requester, one byte; optional input change + req drop at cycle chg.
    task automatic run_single(input int idx, input logic rs, input logic [7:0] d, input int chg);
        exp_t e;
        int   last;
        e    = mk(idx, rs, d, 0);
        last = SETUP + PULSE + HOLD + e.wait_c;
        sb.push_back(e);
        @(posedge clk_i); #1;
        req_i[idx]             = 1'b1;
        rs_in_i[idx]           = rs;
        data_in_i[8*idx +: 8]  = d;
        for (int c = 1; c <= last + 1; c++) begin
            @(posedge clk_i); #1;
            if (c == chg) begin
                rs_in_i[idx]          = ~rs;
                data_in_i[8*idx +: 8] = ~d;
                req_i[idx]            = 1'b0;
            end
            if (c == last + 1) req_i[idx] = 1'b0;
            @(negedge clk_i);
            if (c == 1) check_eq("single_grant", 32'(grant_o), 32'(e.grant));
            if (c <= last) check_eq("single_data", 32'(lcd_data_o), 32'(d));
            check_eq("single_en", 32'(lcd_enable_o), 32'(c >= SETUP + 1 && c <= SETUP + PULSE));
            check_eq("single_done", 32'(done_o), (c == last) ? 32'(e.grant) : 32'h0);
            if (c == last + 1) check_eq("single_idle", 32'(busy_o), 0);
        end
    endtask

    initial begin
        reset_i   = 1'b1;
        req_i     = '0;
        lock_i    = '0;
        rs_in_i   = '0;
        data_in_i = '0;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        check_eq("rst_grant", 32'(grant_o), 0);
        check_eq("rst_done", 32'(done_o), 0);
        check_eq("rst_busy", 32'(busy_o), 0);
        check_eq("rst_rs", 32'(lcd_rs_o), 0);
        check_eq("rst_rw", 32'(lcd_rw_o), 0);
        check_eq("rst_en", 32'(lcd_enable_o), 0);
        check_eq("rst_data", 32'(lcd_data_o), 0);

        // Single byte; leaves rr pointer at 2.
        run_single(1, 1'b1, 8'h41, 0);

        // Reset in the middle of PULSE, then rr must restart from 0.
        sb.push_back(mk(1, 1'b1, 8'h33, 0));
        @(posedge clk_i); #1;
        req_i[1] = 1'b1; rs_in_i[1] = 1'b1; data_in_i[15:8] = 8'h33;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk_i); #1;
            if (c == 4) reset_i = 1'b1;
            if (c == 5) begin
                reset_i = 1'b0;
                req_i   = '0;
            end
            @(negedge clk_i);
            if (c == 4) check_eq("rstmid_en_before", 32'(lcd_enable_o), 1);
        end
        check_eq("rstmid_en", 32'(lcd_enable_o), 0);
        check_eq("rstmid_grant", 32'(grant_o), 0);
        check_eq("rstmid_data", 32'(lcd_data_o), 0);
        check_eq("rstmid_busy", 32'(busy_o), 0);
        check_eq("rstmid_done", 32'(done_o), 0);
        check_eq("rstmid_rs", 32'(lcd_rs_o), 0);
        rs_in_i = 3'b010; data_in_i = {8'h62, 8'h51, 8'h40};
        sb.push_back(mk(1, 1'b1, 8'h51, 0));
        @(posedge clk_i); #1;
        req_i = 3'b110;
        wait_dones(1, 40);
        req_i = '0;

        // Round robin with all three requesting.
        do_reset();
        rs_in_i = 3'b010; data_in_i = {8'h32, 8'h21, 8'h10};
        sb.push_back(mk(0, 1'b0, 8'h10, 0));
        sb.push_back(mk(1, 1'b1, 8'h21, 1));
        sb.push_back(mk(2, 1'b0, 8'h32, 1));
        sb.push_back(mk(0, 1'b0, 8'h10, 1));
        req_i = 3'b111;
        wait_dones(4, 80);
        req_i = '0;

        // Lock burst by requester 0, then requester 2.
        do_reset();
        rs_in_i = 3'b101; data_in_i = {8'h49, 8'h00, 8'h48};
        sb.push_back(mk(0, 1'b1, 8'h48, 0));
        for (int i = 0; i < 3; i++) sb.push_back(mk(0, 1'b1, 8'h48, 1));
        sb.push_back(mk(2, 1'b1, 8'h49, 1));
        lock_i = 3'b001;
        req_i  = 3'b101;
        wait_dones(3, 60);
        lock_i = '0;
        wait_dones(1, 20);
        req_i[0] = 1'b0;
        wait_dones(1, 20);
        req_i = '0;

        // Inputs change and req drops mid-transaction.
        do_reset();
        run_single(2, 1'b0, 8'h55, 4);

        // Clear command and an ordinary command.
        do_reset();
        run_single(0, 1'b0, 8'h01, 0);
        run_single(1, 1'b0, 8'h38, 0);

        check_eq("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
